// File: rtl/beat_width_narrower_if.sv
// Wide-beat in / narrow-word out stream bundle for beat_width_narrower.
// The slave modport is the narrower's view; master is the environment driving it.
interface beat_width_narrower_if #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64
);
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/beat_width_narrower.sv
// Splits each accepted wide beat into RATIO narrow words, LSB slice first,
// with zero-bubble reload on the last word and free-running debug counters.
module beat_width_narrower #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  beat_width_narrower_if.slave  bus,
  output logic                  busy,
  output logic [31:0]           beat_count,
  output logic [31:0]           word_count
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(RATIO);

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t                             state_q, state_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0]    hold_reg, hold_d;
  logic [IDX_W-1:0]                   idx, idx_d;
  logic                               hold_valid;
  logic                               last_word;
  logic                               word_fire;
  logic                               accept;

  assign hold_valid    = (state_q == DRAIN);
  assign last_word     = (idx == IDX_W'(RATIO - 1));
  assign word_fire     = hold_valid && bus.out_ready;
  assign bus.in_ready  = !hold_valid || (bus.out_ready && last_word);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_data  = hold_reg[idx];
  assign bus.out_valid = hold_valid;
  assign busy          = hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      hold_reg   <= '0;
      idx        <= '0;
      beat_count <= '0;
      word_count <= '0;
    end else begin
      state_q    <= state_d;
      hold_reg   <= hold_d;
      idx        <= idx_d;
      beat_count <= beat_count + 32'(accept);
      word_count <= word_count + 32'(word_fire);
    end
  end

  // A new beat is only taken while empty or as the final word leaves,
  // so the holding register is never overwritten with words still pending.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_reg;
    idx_d   = idx;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          hold_d  = bus.in_data;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (word_fire) begin
          if (!last_word) begin
            idx_d = idx + IDX_W'(1);
          end else if (bus.in_valid) begin
            hold_d = bus.in_data;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_beat_width_narrower.sv
// Randomized self-checking bench for beat_width_narrower against a queue-based
// model: each accepted beat becomes RATIO words pushed LSB slice first.
module tb_beat_width_narrower;
  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int RATIO = IN_W / OUT_W;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [31:0] beat_count;
  logic [31:0] word_count;

  beat_width_narrower_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

  beat_width_narrower #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .busy       (busy),
    .beat_count (beat_count),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OUT_W-1:0] exp_q[$];
  logic [31:0]      m_bc;
  logic [31:0]      m_wc;
  logic             inv_en;
  int               n_cmp;
  int               n_err;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] makeBeat(input logic [63:0] base);
    logic [IN_W-1:0] r;
    for (int k = 0; k < RATIO; k++) r[k*OUT_W +: OUT_W] = base + 64'(k);
    return r;
  endfunction

  function automatic logic [IN_W-1:0] randBeat();
    logic [IN_W-1:0] r;
    for (int k = 0; k < IN_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkAll(input logic exp_rdy);
    logic [31:0] inv;
    checkOutput("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    checkOutput("busy", 64'(busy), 64'(exp_q.size() != 0));
    checkOutput("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (exp_q.size() != 0) checkOutput("out_data", 64'(bus.out_data), 64'(exp_q[0]));
    checkOutput("beat_count", 64'(beat_count), 64'(m_bc));
    checkOutput("word_count", 64'(word_count), 64'(m_wc));
    if (inv_en) begin
      inv = 32'(RATIO) * beat_count - 32'(exp_q.size());
      checkOutput("count_invariant", 64'(word_count), 64'(inv));
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model at posedge.
  task automatic applyStimulus(input logic iv, input logic [IN_W-1:0] d, input logic ordy);
    logic exp_rdy, fire, acc;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
    checkAll(exp_rdy);
    fire = ordy && (exp_q.size() != 0);
    acc  = iv && exp_rdy;
    @(posedge clk);
    if (fire) begin
      void'(exp_q.pop_front());
      m_wc = m_wc + 32'd1;
    end
    if (acc) begin
      for (int k = 0; k < RATIO; k++) exp_q.push_back(d[k*OUT_W +: OUT_W]);
      m_bc = m_bc + 32'd1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, "_beat_count"}, 64'(beat_count), 64'd0);
    checkOutput({tag, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  task automatic resetDut(input string tag);
    rst_n = 1'b0;
    #1;
    checkResetValues(tag);
    exp_q.delete();
    m_bc   = '0;
    m_wc   = '0;
    inv_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    inv_en        = 1'b1;
    m_bc          = '0;
    m_wc          = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #3;
    resetDut("reset");

    // Single beat, word k = k.
    applyStimulus(1'b1, makeBeat(64'h0), 1'b1);
    for (int i = 0; i < RATIO + 2; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("single_beat_count", 64'(beat_count), 64'd1);
    checkOutput("single_word_count", 64'(word_count), 64'd8);

    // Back-to-back: four beats with in_valid held high.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < RATIO; i++) applyStimulus(1'b1, makeBeat(64'h100 * (b + 1)), 1'b1);
    end
    for (int i = 0; i < RATIO + 2; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("b2b_beat_count", 64'(beat_count), 64'd5);
    checkOutput("b2b_word_count", 64'(word_count), 64'd40);

    // Backpressure with out_ready pattern 1,0,0,1.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(i < 40, randBeat(), (i % 4 == 0) || (i % 4 == 3));
    end
    for (int i = 0; i < 2 * RATIO + 2; i++) applyStimulus(1'b0, '0, 1'b1);

    // Reset asserted between edges after word 3 of a beat.
    applyStimulus(1'b1, makeBeat(64'h50), 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);
    #3;
    resetDut("mid_reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, makeBeat(64'hA0), 1'b1);
    for (int i = 0; i < RATIO + 2; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_reset_words", 64'(word_count), 64'd8);

    // Counter wrap: preload both counters to all-ones while idle.
    force dut.beat_count = 32'hFFFF_FFFF;
    force dut.word_count = 32'hFFFF_FFFF;
    #1;
    release dut.beat_count;
    release dut.word_count;
    m_bc   = 32'hFFFF_FFFF;
    m_wc   = 32'hFFFF_FFFF;
    inv_en = 1'b0;
    applyStimulus(1'b1, randBeat(), 1'b1);
    for (int i = 0; i < RATIO + 1; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("wrap_beat_count", 64'(beat_count), 64'd0);
    checkOutput("wrap_word_count", 64'(word_count), 64'd7);
    #3;
    resetDut("wrap_reset");

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom % 4) != 0, randBeat(), ($urandom % 3) != 0);
    end
    for (int i = 0; i < 4 * RATIO; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("soak_drained", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
